act_share_arbiter: RTL and testbench



---
 rtl/act_share_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_act_share_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/act_share_arbiter.sv
// -----------------------------------------------------------------------------
// act_share_arbiter
//
// Round-robin controller that time-shares one activation-function unit
// (data/dataOut/enable/rdy handshake) between NUM_REQ producer lanes.
// One operation is in flight at a time: IDLE grants a lane and latches its
// operand, ISSUE strobes the unit, WAIT holds until the unit answers,
// RESP returns the result to the granted lane.
//
// Parameters
//   WIDTH    operand/result width (signed two's complement)
//   NUM_REQ  number of requesting lanes, 2..8
//   TIMEOUT  WAIT cycles before an operation is aborted (timeout build only)
//
// Ports
//   iClk, iRst    clock, asynchronous active-low reset
//   req           per-lane request, level-held until gnt
//   reqData       per-lane operands, lane k at [k*WIDTH +: WIDTH]
//   gnt           one-hot grant pulse (operand latched in that cycle)
//   rspValid      one-hot response pulse for the served lane
//   rspData       result, zero whenever rspValid is zero
//   rspErr        response was produced by a timeout
//   busy          high in every state except IDLE
//   actData       operand to the shared unit
//   actEnable     one-cycle issue strobe to the shared unit
//   actDataOut    result from the shared unit
//   actRdy        result-valid from the shared unit
//
// Build option
//   ACT_SHARE_TIMEOUT_EN  when defined, WAIT is bounded by TIMEOUT cycles and
//                         an expired operation returns rspData=0, rspErr=1.
//                         When undefined, WAIT is unbounded and rspErr is 0.
// -----------------------------------------------------------------------------
module act_share_arbiter #(
    parameter int WIDTH   = 8,
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                       iClk,
    input  logic                       iRst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*WIDTH-1:0]   reqData,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [NUM_REQ-1:0]         rspValid,
    output logic [WIDTH-1:0]           rspData,
    output logic                       rspErr,
    output logic                       busy,
    output logic [WIDTH-1:0]           actData,
    output logic                       actEnable,
    input  logic [WIDTH-1:0]           actDataOut,
    input  logic                       actRdy
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int SW = PW + 1;

    // Reject unsupported configurations at elaboration time.
    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_bad_params
        $error("act_share_arbiter: NUM_REQ must be 2..8 and TIMEOUT >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e               state_q;
    logic [PW-1:0]        ptr_q;
    logic [PW-1:0]        tag_q;
    logic [WIDTH-1:0]     op_q;
    logic [WIDTH-1:0]     rsp_data_q;
    logic [NUM_REQ-1:0]   rsp_valid_q;
    logic                 act_en_q;
    logic                 busy_q;

`ifdef ACT_SHARE_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0]        wait_cnt_q;
    logic                 rsp_err_q;
`endif

    // Operand lanes as an array so the winner can index them directly.
    logic [WIDTH-1:0] lane_data [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
        assign lane_data[gi] = reqData[gi*WIDTH +: WIDTH];
    end

    // Rotate the request vector so bit 0 is the lane at ptr; the first set
    // bit of the rotated vector is then the round-robin winner's offset.
    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;

    assign req_dbl = {req, req};
    assign req_rot = NUM_REQ'(req_dbl >> ptr_q);

    logic          win_vld_d;
    logic [PW-1:0] win_off_d;

    always_comb begin
        win_vld_d = 1'b0;
        win_off_d = '0;
        // Descending scan: the lowest set offset is written last and wins.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                win_vld_d = 1'b1;
                win_off_d = PW'(i);
            end
        end
    end

    // Winner lane = (ptr + offset) mod NUM_REQ, done with one conditional
    // subtract so non-power-of-two lane counts wrap correctly.
    logic [SW-1:0] win_sum_d;
    logic [PW-1:0] win_idx_d;
    logic [PW-1:0] ptr_d;

    assign win_sum_d = {1'b0, ptr_q} + {1'b0, win_off_d};
    assign win_idx_d = (win_sum_d >= SW'(NUM_REQ)) ? PW'(win_sum_d - SW'(NUM_REQ))
                                                   : PW'(win_sum_d);

    // The lane just served drops to lowest priority.
    assign ptr_d = (tag_q == PW'(NUM_REQ - 1)) ? '0 : tag_q + 1'b1;

    // Grant is combinational so the operand is captured in the grant cycle;
    // it is gated by reset so it reads 0 while reset is asserted.
    assign gnt = (state_q == S_IDLE && win_vld_d && iRst)
               ? (NUM_REQ'(1) << win_idx_d) : '0;

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            tag_q       <= '0;
            op_q        <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= '0;
            act_en_q    <= 1'b0;
            busy_q      <= 1'b0;
`ifdef ACT_SHARE_TIMEOUT_EN
            wait_cnt_q  <= '0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (win_vld_d) begin
                        op_q     <= lane_data[win_idx_d];
                        tag_q    <= win_idx_d;
                        act_en_q <= 1'b1;
                        busy_q   <= 1'b1;
                        state_q  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    act_en_q <= 1'b0;
`ifdef ACT_SHARE_TIMEOUT_EN
                    wait_cnt_q <= '0;
`endif
                    state_q  <= S_WAIT;
                end
                S_WAIT: begin
                    // actRdy in the final counted cycle still wins over timeout.
                    if (actRdy) begin
                        rsp_data_q  <= actDataOut;
                        rsp_valid_q <= NUM_REQ'(1) << tag_q;
`ifdef ACT_SHARE_TIMEOUT_EN
                        rsp_err_q   <= 1'b0;
`endif
                        state_q     <= S_RESP;
                    end
`ifdef ACT_SHARE_TIMEOUT_EN
                    else if (wait_cnt_q == CW'(TIMEOUT - 1)) begin
                        rsp_data_q  <= '0;
                        rsp_valid_q <= NUM_REQ'(1) << tag_q;
                        rsp_err_q   <= 1'b1;
                        state_q     <= S_RESP;
                    end else begin
                        wait_cnt_q  <= wait_cnt_q + 1'b1;
                    end
`endif
                end
                S_RESP: begin
                    rsp_valid_q <= '0;
                    rsp_data_q  <= '0;
`ifdef ACT_SHARE_TIMEOUT_EN
                    rsp_err_q   <= 1'b0;
`endif
                    busy_q      <= 1'b0;
                    ptr_q       <= ptr_d;
                    state_q     <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign rspValid  = rsp_valid_q;
    assign rspData   = rsp_data_q;
    assign busy      = busy_q;
    assign actEnable = act_en_q;
    assign actData   = op_q;

`ifdef ACT_SHARE_TIMEOUT_EN
    assign rspErr = rsp_err_q;
`else
    assign rspErr = 1'b0;
`endif

endmodule

// File: tb/tb_act_share_arbiter.sv
module tb_act_share_arbiter;

    localparam int WIDTH   = 8;
    localparam int NUM_REQ = 4;
    localparam int TIMEOUT = 15;
    localparam logic [WIDTH-1:0] HOLD_VAL = 8'h5A;

    logic                     clk;
    logic                     rst_n;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] reqData;
    logic [NUM_REQ-1:0]       gnt;
    logic [NUM_REQ-1:0]       rspValid;
    logic [WIDTH-1:0]         rspData;
    logic                     rspErr;
    logic                     busy;
    logic [WIDTH-1:0]         actData;
    logic                     actEnable;
    logic [WIDTH-1:0]         actDataOut;
    logic                     actRdy;

    int n_chk  = 0;
    int n_fail = 0;
    int ptr_m  = 0;        // reference round-robin pointer
    int unit_lat = 1;      // 0 = unit never answers
    bit unit_hold = 1'b0;  // unit holds rdy high with HOLD_VAL

    act_share_arbiter #(
        .WIDTH   (WIDTH),
        .NUM_REQ (NUM_REQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .iClk       (clk),
        .iRst       (rst_n),
        .req        (req),
        .reqData    (reqData),
        .gnt        (gnt),
        .rspValid   (rspValid),
        .rspData    (rspData),
        .rspErr     (rspErr),
        .busy       (busy),
        .actData    (actData),
        .actEnable  (actEnable),
        .actDataOut (actDataOut),
        .actRdy     (actRdy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Shared unit model: a relu that answers unit_lat cycles after enable.
    function automatic logic [WIDTH-1:0] relu(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? '0 : x;
    endfunction

    initial begin
        bit               pend;
        int               cnt;
        logic [WIDTH-1:0] op_cap;
        pend = 1'b0;
        cnt = 0;
        op_cap = '0;
        actRdy = 1'b0;
        actDataOut = '0;
        forever begin
            @(posedge clk);
            #1;
            if (unit_hold) begin
                actRdy = 1'b1;
                actDataOut = HOLD_VAL;
                pend = 1'b0;
            end else begin
                actRdy = 1'b0;
                actDataOut = WIDTH'($urandom);
                if (!rst_n) begin
                    pend = 1'b0;
                end else if (pend) begin
                    cnt--;
                    if (cnt == 0) begin
                        actRdy = 1'b1;
                        actDataOut = relu(op_cap);
                        pend = 1'b0;
                    end
                end else if (actEnable && unit_lat > 0) begin
                    pend = 1'b1;
                    cnt = unit_lat;
                    op_cap = actData;
                end
            end
        end
    end

    // Reference arbitration: first requesting lane scanning from ptr.
    function automatic int rr_pick(input int p, input logic [NUM_REQ-1:0] r);
        for (int i = 0; i < NUM_REQ; i++) begin
            int k;
            k = (p + i) % NUM_REQ;
            if (r[k]) return k;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ptr_m = 0;
    endtask

    // Entered at a negedge with the DUT in IDLE; returns at the negedge of
    // the following IDLE cycle. lat = 0 expects a timeout response.
    task automatic run_op(input logic [NUM_REQ-1:0] r, input int lat,
                          input bit keep, output int w);
        logic [WIDTH-1:0]   op;
        logic [WIDTH-1:0]   exp_data;
        logic [NUM_REQ-1:0] oh;
        int                 wait_cycles;
        unit_lat = lat;
        req = r;
        #1;
        w = rr_pick(ptr_m, r);
        oh = NUM_REQ'(1) << w;
        op = reqData[w*WIDTH +: WIDTH];
        chk("gnt", 32'(gnt), 32'(oh));
        chk("idle_busy", 32'(busy), 0);
        @(negedge clk);
        chk("issue_en", 32'(actEnable), 1);
        chk("issue_data", 32'(actData), 32'(op));
        chk("issue_gnt", 32'(gnt), 0);
        chk("issue_busy", 32'(busy), 1);
        if (!keep) req[w] = 1'b0;
        reqData = (NUM_REQ*WIDTH)'($urandom);
        wait_cycles = (lat == 0) ? TIMEOUT : lat;
        if (unit_hold) wait_cycles = 1;
        repeat (wait_cycles) begin
            @(negedge clk);
            chk("wait_en", 32'(actEnable), 0);
            chk("wait_data", 32'(actData), 32'(op));
            chk("wait_rspv", 32'(rspValid), 0);
            chk("wait_rspd", 32'(rspData), 0);
            chk("wait_busy", 32'(busy), 1);
        end
        @(negedge clk);
        exp_data = (lat == 0) ? '0 : (unit_hold ? HOLD_VAL : relu(op));
        chk("rsp_valid", 32'(rspValid), 32'(oh));
        chk("rsp_data", 32'(rspData), 32'(exp_data));
        chk("rsp_err", 32'(rspErr), (lat == 0) ? 1 : 0);
        chk("rsp_busy", 32'(busy), 1);
        chk("rsp_en", 32'(actEnable), 0);
        ptr_m = (w + 1) % NUM_REQ;
        @(negedge clk);
    endtask

    initial begin
        int w;
        logic [NUM_REQ-1:0] r;
        rst_n = 1'b0;
        req = '1;
        reqData = (NUM_REQ*WIDTH)'($urandom);

        // Reset state, with every lane requesting.
        @(negedge clk);
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_rspv", 32'(rspValid), 0);
        chk("rst_rspd", 32'(rspData), 0);
        chk("rst_err", 32'(rspErr), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_en", 32'(actEnable), 0);
        chk("rst_data", 32'(actData), 0);
        req = '0;
        rst_n = 1'b1;

        // Single request on lane 2 with operand -5.
        reqData[2*WIDTH +: WIDTH] = 8'hFB;
        run_op(4'b0100, 1, 1'b0, w);
        chk("t1_busy_low", 32'(busy), 0);
        chk("t1_gnt_low", 32'(gnt), 0);

        // All lanes continuously requesting after reset: 0,1,2,3,0.
        do_reset();
        reqData = (NUM_REQ*WIDTH)'($urandom);
        for (int i = 0; i < 5; i++) run_op(4'b1111, 1, 1'b1, w);

        // Lane 1 just served, lanes 0 and 1 request: lane 0 must win.
        req = '0;
        @(negedge clk);
        run_op(4'b0010, 1, 1'b0, w);
        run_op(4'b0011, 1, 1'b0, w);
        req = '0;
        @(negedge clk);

        // Slow unit: rdy six cycles after enable.
        run_op(4'b0100, 6, 1'b0, w);

        // Unit holds rdy high throughout: accepted once only.
        unit_hold = 1'b1;
        run_op(4'b1000, 1, 1'b0, w);
        chk("hold_rspv_once", 32'(rspValid), 0);
        chk("hold_idle", 32'(busy), 0);
        @(negedge clk);
        chk("hold_rspv_after", 32'(rspValid), 0);
        unit_hold = 1'b0;
        @(negedge clk);

        // Request withdrawn before the grant edge: nothing is latched.
        req = 4'b0100;
        #3;
        req = '0;
        @(negedge clk);
        chk("withdraw_busy", 32'(busy), 0);
        chk("withdraw_en", 32'(actEnable), 0);

        // Asynchronous reset during WAIT.
        unit_lat = 0;
        req = 4'b0010;
        @(negedge clk);
        req = '0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_gnt", 32'(gnt), 0);
        chk("arst_rspv", 32'(rspValid), 0);
        chk("arst_rspd", 32'(rspData), 0);
        chk("arst_err", 32'(rspErr), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_en", 32'(actEnable), 0);
        chk("arst_data", 32'(actData), 0);
        repeat (3) begin
            @(negedge clk);
            chk("arst_hold_rspv", 32'(rspValid), 0);
        end
        rst_n = 1'b1;
        ptr_m = 0;
        reqData = (NUM_REQ*WIDTH)'($urandom);
        run_op(4'b1000, 1, 1'b0, w);
        run_op(4'b1001, 1, 1'b0, w);
        req = '0;
        @(negedge clk);

        // Unit never answers.
`ifdef ACT_SHARE_TIMEOUT_EN
        run_op(4'b0001, 0, 1'b0, w);
`else
        unit_lat = 0;
        req = 4'b0001;
        @(negedge clk);
        req = '0;
        repeat (20) begin
            @(negedge clk);
            chk("stuck_busy", 32'(busy), 1);
            chk("stuck_rspv", 32'(rspValid), 0);
        end
        do_reset();
`endif

        // Randomised operations against the reference model.
        for (int n = 0; n < 40; n++) begin
            r = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
            run_op(r, int'($urandom_range(1, 4)), 1'b0, w);
            if ($urandom_range(0, 3) == 0) begin
                req = '0;
                @(negedge clk);
                chk("gap_busy", 32'(busy), 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
